// File: rtl/multi_ce_pkg.sv
// Shared types and helpers for the multi-channel clock-enable generator.
//   auto_st_e   : channel-0 auto-rate FSM states
//   FRAME_MUL   : frames per second assumed by the auto-rate estimator
//   clamp_rate(): clamp a rate to [lo, hi]. It works on a 64-bit carrier so
//                 any ACC_W up to 58 can share one function. Callers
//                 zero-extend their operands and truncate the result.
package multi_ce_pkg;

    localparam int FRAME_MUL = 60;

    typedef logic [63:0] wide_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOCKED
    } auto_st_e;

    function automatic wide_t clamp_rate(input wide_t v, input wide_t lo, input wide_t hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/multi_ce_gen_accum.sv
// One fractional clock-enable channel.
//   clk_sys, reset_n : clock, async active-low reset
//   enable_i         : run; low holds the phase accumulator and silences ce
//   rate_i           : target rate in Hz (clamped to CLK_HZ in the rate stage)
//   sync_i           : clear the accumulator (beats both tick and enable)
//   ce_o             : registered single-cycle enable
// Accumulates rate_q modulo CLK_HZ. A wrap produces one ce, so the long-run
// ce rate is exactly rate_q/CLK_HZ.
module ce_accum
    import multi_ce_pkg::*;
#(
    parameter int          ACC_W  = 32,
    parameter int unsigned CLK_HZ = 42000000
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic [ACC_W-1:0] rate_i,
    input  logic             sync_i,
    output logic             ce_o
);

    localparam logic [ACC_W-1:0] MOD = ACC_W'(CLK_HZ);

    logic [ACC_W-1:0] rate_q, rate_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] nxt;
    logic             ce_q, ce_d;

    always_comb begin
        rate_d = ACC_W'(clamp_rate(wide_t'(rate_i), '0, wide_t'(CLK_HZ)));
        // acc < CLK_HZ and rate_q <= CLK_HZ, so nxt < 2*CLK_HZ fits ACC_W.
        nxt    = acc_q + rate_q;
        acc_d  = acc_q;
        ce_d   = 1'b0;
        if (sync_i) begin
            acc_d = '0;
        end else if (enable_i) begin
            if (nxt >= MOD) begin
                acc_d = nxt - MOD;
                ce_d  = 1'b1;
            end else begin
                acc_d = nxt;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rate_q <= '0;
            acc_q  <= '0;
            ce_q   <= 1'b0;
        end else begin
            rate_q <= rate_d;
            acc_q  <= acc_d;
            ce_q   <= ce_d;
        end
    end

    assign ce_o = ce_q;

endmodule

// File: rtl/multi_ce_gen.sv
// Multi-channel fractional clock-enable generator.
//   clk_sys, reset_n : clock, async active-low reset
//   enable_i[n]      : channel run enable
//   rate_i           : per-channel target Hz, channel n at [n*ACC_W +: ACC_W]
//   sync_i[n]        : channel phase-align (clear accumulator)
//   ce_o[n]          : single-cycle clock enables
//   rate_o           : effective channel-0 rate (registered)
//   vs_i, auto_en_i  : only with MULTI_CE_AUTORATE_EN. Frame sync and
//                      auto-rate permit for channel 0.
// Build option MULTI_CE_AUTORATE_EN adds an FSM. The FSM measures ch0 ce pulses
// per frame and retunes ch0 to cnt*60 Hz, clamped to [MIN_HZ, CLK_HZ].
module multi_ce_gen
    import multi_ce_pkg::*;
#(
    parameter int          CHANNELS = 2,
    parameter int          ACC_W    = 32,
    parameter int unsigned CLK_HZ   = 42000000,
    parameter int unsigned MIN_HZ   = 5000000
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       enable_i,
    input  logic [CHANNELS*ACC_W-1:0] rate_i,
    input  logic [CHANNELS-1:0]       sync_i,
`ifdef MULTI_CE_AUTORATE_EN
    input  logic                      vs_i,
    input  logic                      auto_en_i,
`endif
    output logic [CHANNELS-1:0]       ce_o,
    output logic [ACC_W-1:0]          rate_o
);

    logic [ACC_W-1:0] rate0_in;
    logic [ACC_W-1:0] ch0_rate;
    logic [ACC_W-1:0] rate_o_q, rate_o_d;

    assign rate0_in = rate_i[ACC_W-1:0];

`ifdef MULTI_CE_AUTORATE_EN
    // est = cnt*60 needs 6 extra bits of headroom.
    localparam int EST_W = ACC_W + 6;

    auto_st_e         st_q, st_d;
    logic             vs_q;
    logic             vs_rise;
    logic [ACC_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [EST_W-1:0] est_q, est_d, cnt_w;
    logic [ACC_W-1:0] rate0_prev_q;

    always_comb begin
        vs_rise = vs_i & ~vs_q;
        // A ce landing on the closing vs edge still belongs to that frame.
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + ACC_W'(ce_o[0]);
        cnt_w   = {6'b0, cnt_inc};
        st_d    = st_q;
        cnt_d   = cnt_q;
        est_d   = est_q;
        case (st_q)
            IDLE: begin
                if (auto_en_i && vs_rise) begin
                    st_d  = ARMED;
                    cnt_d = '0;
                end
            end
            ARMED, LOCKED: begin
                cnt_d = cnt_inc;
                if (vs_rise) begin
                    // cnt * FRAME_MUL as 32+16+8+4
                    est_d = (cnt_w << 5) + (cnt_w << 4) + (cnt_w << 3) + (cnt_w << 2);
                    cnt_d = '0;
                    st_d  = LOCKED;
                end
                if (!auto_en_i || (st_q == LOCKED && rate0_in != rate0_prev_q)) begin
                    st_d = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
        ch0_rate = (st_q == LOCKED)
                 ? ACC_W'(clamp_rate(wide_t'(est_q), wide_t'(MIN_HZ), wide_t'(CLK_HZ)))
                 : rate0_in;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            st_q         <= IDLE;
            vs_q         <= 1'b0;
            cnt_q        <= '0;
            est_q        <= '0;
            rate0_prev_q <= '0;
        end else begin
            st_q         <= st_d;
            vs_q         <= vs_i;
            cnt_q        <= cnt_d;
            est_q        <= est_d;
            rate0_prev_q <= rate0_in;
        end
    end
`else
    assign ch0_rate = rate0_in;
`endif

    assign rate_o_d = ACC_W'(clamp_rate(wide_t'(ch0_rate), '0, wide_t'(CLK_HZ)));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rate_o_q <= '0;
        else          rate_o_q <= rate_o_d;
    end

    assign rate_o = rate_o_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [ACC_W-1:0] ch_rate;
        if (g == 0) begin : g_c0
            assign ch_rate = ch0_rate;
        end else begin : g_cn
            assign ch_rate = rate_i[g*ACC_W +: ACC_W];
        end
        ce_accum #(
            .ACC_W  (ACC_W),
            .CLK_HZ (CLK_HZ)
        ) u_acc (
            .clk_sys  (clk_sys),
            .reset_n  (reset_n),
            .enable_i (enable_i[g]),
            .rate_i   (ch_rate),
            .sync_i   (sync_i[g]),
            .ce_o     (ce_o[g])
        );
    end

endmodule
